bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 95 +++++++++
 tb/tb_bcd_display_scan.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for a BCD display with a double-buffered digit register.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_SCAN_LZB_EN.
module bcd_display_scan #(
  parameter int numberOfDigits = 3,
  parameter int busWidth       = 4,
  parameter int scanDiv        = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load,
  input  logic [numberOfDigits-1:0][busWidth-1:0]  digitIn,
  output logic [6:0]                               seg,
  output logic [numberOfDigits-1:0]                an,
  output logic                                     frameStart
);

  localparam int PW = (scanDiv > 1) ? $clog2(scanDiv) : 1;
  localparam int IW = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(scanDiv - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(numberOfDigits - 1);
  localparam logic [busWidth-1:0] DIGIT_MAX  = busWidth'(9);

  logic [PW-1:0]                             presc;
  logic [IW-1:0]                             idx;
  logic [numberOfDigits-1:0][busWidth-1:0]   shadow;
  logic [numberOfDigits-1:0][busWidth-1:0]   display;
  logic                                      presc_wrap;
  logic                                      frame_wrap;
  logic [busWidth-1:0]                       cur;
  logic                                      blank;

  assign presc_wrap = (presc == PRESC_LAST);
  assign frame_wrap = presc_wrap && (idx == IDX_LAST);

  // display only ever changes on the frame boundary, so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      display    <= '0;
      frameStart <= 1'b0;
    end else begin
      presc      <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (load)
        shadow <= digitIn;
      if (frame_wrap)
        display <= shadow;
      frameStart <= frame_wrap;
    end
  end

  assign an  = numberOfDigits'(1) << idx;
  assign cur = display[idx];

`ifdef BCD_DISPLAY_SCAN_LZB_EN
  logic [numberOfDigits-1:0] zero_from;

  // zero_from[k]: digit k and every digit above it are zero
  always_comb begin
    zero_from = '0;
    zero_from[numberOfDigits-1] = (display[numberOfDigits-1] == '0);
    for (int k = numberOfDigits - 2; k >= 0; k--)
      zero_from[k] = zero_from[k+1] && (display[k] == '0);
  end

  assign blank = (idx != '0) && zero_from[idx];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg = 7'h40;
    if (blank) begin
      seg = 7'h00;
    end else if (cur <= DIGIT_MAX) begin
      case (cur[3:0])
        4'd0:    seg = 7'h3F;
        4'd1:    seg = 7'h06;
        4'd2:    seg = 7'h5B;
        4'd3:    seg = 7'h4F;
        4'd4:    seg = 7'h66;
        4'd5:    seg = 7'h6D;
        4'd6:    seg = 7'h7D;
        4'd7:    seg = 7'h07;
        4'd8:    seg = 7'h7F;
        4'd9:    seg = 7'h6F;
        default: seg = 7'h40;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a frame-level reference model predicts every cycle's outputs.
// Honours BCD_DISPLAY_SCAN_LZB_EN in the reference model when the design is built with it.
module tb_bcd_display_scan;
  localparam int N = 3;
  localparam int W = 4;
  localparam int S = 4;
  localparam int F = N * S;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   load = 1'b0;
  logic [N-1:0][W-1:0]    digitIn = '0;
  logic [6:0]             seg;
  logic [N-1:0]           an;
  logic                   frameStart;

  bcd_display_scan #(.numberOfDigits(N), .busWidth(W), .scanDiv(S)) dut (
    .clk(clk), .rst(rst), .load(load), .digitIn(digitIn),
    .seg(seg), .an(an), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fs;
    int           t;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state: cycles since reset, pending digits, digits on display
  int t = 0;
  int shadow [N];
  int disp   [N];
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] ref_seg(int k);
    int v;
    v = disp[k];
`ifdef BCD_DISPLAY_SCAN_LZB_EN
    begin
      bit all0;
      all0 = 1'b1;
      for (int j = k; j < N; j++) if (disp[j] != 0) all0 = 1'b0;
      if (k > 0 && all0) return 7'h00;
    end
`endif
    if (v > 9) return 7'h40;
    return segtab[v];
  endfunction

  task automatic step(input logic r, input logic l, input logic [N-1:0][W-1:0] d);
    exp_t e;
    int i;
    rst = r; load = l; digitIn = d;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0;
      for (int k = 0; k < N; k++) begin shadow[k] = 0; disp[k] = 0; end
    end else begin
      t++;
      if (t % F == 0)
        for (int k = 0; k < N; k++) disp[k] = shadow[k];
      if (l)
        for (int k = 0; k < N; k++) shadow[k] = int'(d[k]);
    end
    i     = (t / S) % N;
    e.an  = N'(1 << i);
    e.seg = ref_seg(i);
    e.fs  = (t > 0) && (t % F == 0);
    e.t   = t;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, '0);
  endtask

  task automatic idle_to_phase(input int p);
    while (t % F != p) step(1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (an !== e.an) begin
        miscompares++;
        $display("FAIL an t=%0d: got %b expected %b", e.t, an, e.an);
      end
      if (seg !== e.seg) begin
        miscompares++;
        $display("FAIL seg t=%0d: got %h expected %h", e.t, seg, e.seg);
      end
      if (frameStart !== e.fs) begin
        miscompares++;
        $display("FAIL frameStart t=%0d: got %b expected %b", e.t, frameStart, e.fs);
      end
    end
  end

  initial begin
    logic [N-1:0][W-1:0] d;
    for (int k = 0; k < N; k++) begin shadow[k] = 0; disp[k] = 0; end

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, {4'h5, 4'h5, 4'h5});
    idle(26);

    idle_to_phase(5);
    step(1'b0, 1'b1, {4'h1, 4'h2, 4'h3});
    idle(26);

    idle_to_phase(11);
    step(1'b0, 1'b1, {4'h0, 4'h0, 4'h7});
    idle(26);

    idle_to_phase(3);
    step(1'b0, 1'b1, {4'hC, 4'h5, 4'h0});
    idle(26);

    idle_to_phase(9);
    step(1'b1, 1'b1, {4'h9, 4'h9, 4'h9});
    idle(26);

    step(1'b0, 1'b1, {4'h0, 4'h5, 4'h0});
    idle(26);

    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++)
        d[k] = ($urandom % 3 == 0) ? 4'h0 : W'($urandom_range(0, 15));
      step(($urandom % 60) == 0, ($urandom % 4) == 0, d);
    end
    step(1'b0, 1'b0, '0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
